// File: rtl/bp_pkg.sv
// Shared types and sizing for the gshare branch predictor and its BTB.
package bp_pkg;
   localparam int GHR_W     = 4;
   localparam int BTB_IDX_W = 4;
   localparam int BTB_N     = 2 ** BTB_IDX_W;
   localparam int PHT_N     = 2 ** GHR_W;
   localparam int TAG_W     = 32 - BTB_IDX_W - 2;

   typedef logic [1:0] sat2_t;
   localparam sat2_t SAT2_WNT = 2'b01;

   typedef struct packed {
      logic             valid;
      logic             is_cond;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
   } btb_entry_t;

   // Two-bit saturating counter step: clamps at 00 and 11.
   function automatic sat2_t sat2_next(sat2_t c, logic up);
      if (up) return (c == 2'b11) ? c : c + 2'd1;
      else    return (c == 2'b00) ? c : c - 2'd1;
   endfunction
endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: two combinational read ports (IF lookup,
// EX target check) and one registered write port. Reads see pre-write contents.
module bp_btb
   import bp_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BTB_IDX_W-1:0] if_idx_i,
   input  logic [BTB_IDX_W-1:0] ex_idx_i,
   input  logic                 wr_en_i,
   input  logic [BTB_IDX_W-1:0] wr_idx_i,
   input  btb_entry_t           wr_entry_i,
   output btb_entry_t           if_entry_o,
   output btb_entry_t           ex_entry_o
);
   btb_entry_t mem_q [BTB_N];

   // Entry storage; reset invalidates everything and wins over a same-cycle write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BTB_N; i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_entry_i;
      end
   end

   assign if_entry_o = mem_q[if_idx_i];
   assign ex_entry_o = mem_q[ex_idx_i];
endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor plus BTB. IF side predicts in the same cycle;
// EX side detects mispredicts, produces the redirect PC and trains all state.
module branch_predictor
   import bp_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      IF_pc,
   input  logic             IF_stall,
   output logic             IF_BTB_hit,
   output logic             IF_prediction,
   output logic [31:0]      IF_target,
   output logic [GHR_W-1:0] IF_pattern_used,
   input  logic             EX_update,
   input  logic             EX_is_cond,
   input  logic [31:0]      EX_pc,
   input  logic             EX_taken,
   input  logic [31:0]      EX_target,
   input  logic             EX_BTB_hit,
   input  logic             EX_prediction,
   input  logic [GHR_W-1:0] EX_pattern_used,
   output logic             EX_mispredict,
   output logic [31:0]      EX_redirect_pc
);
   logic [GHR_W-1:0] ghr_spec_q, ghr_spec_d;
   logic [GHR_W-1:0] ghr_commit_q, ghr_commit_d;
   sat2_t            pht_q [PHT_N];
   btb_entry_t       if_entry, ex_entry, wr_entry;
   logic [GHR_W-1:0] if_pht_idx, ex_pht_idx;
   logic             ex_tgt_match, spec_shift, unused_ok;

   bp_btb u_btb (
      .clk        (clk),
      .reset      (reset),
      .if_idx_i   (IF_pc[BTB_IDX_W+1:2]),
      .ex_idx_i   (EX_pc[BTB_IDX_W+1:2]),
      .wr_en_i    (EX_update && EX_taken),
      .wr_idx_i   (EX_pc[BTB_IDX_W+1:2]),
      .wr_entry_i (wr_entry),
      .if_entry_o (if_entry),
      .ex_entry_o (ex_entry)
   );

   // IF lookup
   assign if_pht_idx      = IF_pc[GHR_W+1:2] ^ ghr_spec_q;
   assign IF_BTB_hit      = if_entry.valid && (if_entry.tag == IF_pc[31:BTB_IDX_W+2]);
   assign IF_prediction   = IF_BTB_hit && (if_entry.is_cond ? pht_q[if_pht_idx][1] : 1'b1);
   assign IF_target       = if_entry.target;
   assign IF_pattern_used = ghr_spec_q;
   assign spec_shift      = IF_BTB_hit && if_entry.is_cond && !IF_stall;

   // EX resolve: a tag miss on the stored entry counts as a target mismatch
   assign ex_pht_idx   = EX_pc[GHR_W+1:2] ^ EX_pattern_used;
   assign ex_tgt_match = ex_entry.valid && (ex_entry.tag == EX_pc[31:BTB_IDX_W+2])
                         && (ex_entry.target == EX_target);
   assign unused_ok    = ^{IF_pc[1:0], ex_entry.is_cond};

   // Mispredict detection and redirect, both idle-low when nothing resolves
   always_comb begin
      EX_mispredict  = 1'b0;
      EX_redirect_pc = '0;
      if (EX_update) begin
         if (EX_is_cond)
            EX_mispredict = (EX_taken != (EX_BTB_hit && EX_prediction)) || (EX_taken && !ex_tgt_match);
         else
            EX_mispredict = !EX_BTB_hit || !ex_tgt_match;
         EX_redirect_pc = EX_taken ? EX_target : EX_pc + 32'd4;
      end
   end

   // BTB fill data for taken resolutions
   always_comb begin
      wr_entry         = '0;
      wr_entry.valid   = 1'b1;
      wr_entry.is_cond = EX_is_cond;
      wr_entry.tag     = EX_pc[31:BTB_IDX_W+2];
      wr_entry.target  = EX_target;
   end

   // History next-state: recovery beats the speculative shift
   always_comb begin
      ghr_spec_d   = ghr_spec_q;
      ghr_commit_d = ghr_commit_q;
      if (EX_update && EX_is_cond) ghr_commit_d = {ghr_commit_q[GHR_W-2:0], EX_taken};
      if (EX_mispredict)
         ghr_spec_d = EX_is_cond ? {ghr_commit_q[GHR_W-2:0], EX_taken} : ghr_commit_q;
      else if (spec_shift)
         ghr_spec_d = {ghr_spec_q[GHR_W-2:0], IF_prediction};
   end

   // History registers and PHT training
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ghr_spec_q   <= '0;
         ghr_commit_q <= '0;
         for (int i = 0; i < PHT_N; i++) pht_q[i] <= SAT2_WNT;
      end else begin
         ghr_spec_q   <= ghr_spec_d;
         ghr_commit_q <= ghr_commit_d;
         if (EX_update && EX_is_cond) pht_q[ex_pht_idx] <= sat2_next(pht_q[ex_pht_idx], EX_taken);
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: expectations are queued when
// stimulus is applied and popped when outputs are sampled mid-cycle.
module tb_branch_predictor;
   logic        clk, reset;
   logic [31:0] IF_pc, IF_target, EX_pc, EX_target, EX_redirect_pc;
   logic        IF_stall, IF_BTB_hit, IF_prediction;
   logic [3:0]  IF_pattern_used, EX_pattern_used;
   logic        EX_update, EX_is_cond, EX_taken, EX_BTB_hit, EX_prediction, EX_mispredict;

   int tests = 0;
   int fails = 0;
   logic [31:0] sb [$];

   branch_predictor dut (
      .clk(clk), .reset(reset), .IF_pc(IF_pc), .IF_stall(IF_stall),
      .IF_BTB_hit(IF_BTB_hit), .IF_prediction(IF_prediction), .IF_target(IF_target),
      .IF_pattern_used(IF_pattern_used), .EX_update(EX_update), .EX_is_cond(EX_is_cond),
      .EX_pc(EX_pc), .EX_taken(EX_taken), .EX_target(EX_target), .EX_BTB_hit(EX_BTB_hit),
      .EX_prediction(EX_prediction), .EX_pattern_used(EX_pattern_used),
      .EX_mispredict(EX_mispredict), .EX_redirect_pc(EX_redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_ex(input logic upd, input logic cond, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic bhit, input logic pred, input logic [3:0] pat);
      EX_update = upd; EX_is_cond = cond; EX_pc = pc; EX_taken = tk;
      EX_target = tgt; EX_BTB_hit = bhit; EX_prediction = pred; EX_pattern_used = pat;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      @(negedge clk); reset = 1'b1; IF_pc = 32'h100;
      sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0);
      #2;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL reset_hit got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      e = sb.pop_front(); tests++; if (IF_prediction !== e[0]) begin fails++; $display("FAIL reset_pred got=%0h exp=%0h", IF_prediction, e[0]); end
      e = sb.pop_front(); tests++; if (IF_pattern_used !== e[3:0]) begin fails++; $display("FAIL reset_pattern got=%0h exp=%0h", IF_pattern_used, e[3:0]); end
      e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL reset_mp got=%0h exp=%0h", EX_mispredict, e[0]); end
      @(negedge clk); reset = 1'b0;
   endtask

   // Cold taken branch: mispredict, BTB allocation, history 0001
   task automatic test_first_train();
      logic [31:0] e;
      @(negedge clk); IF_pc = 32'h100; drive_ex(1, 1, 32'h100, 1, 32'h80, 0, 0, 4'h0);
      sb.push_back(1); sb.push_back(32'h80); sb.push_back(0);
      #2;
      e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL t2_mp got=%0h exp=%0h", EX_mispredict, e[0]); end
      e = sb.pop_front(); tests++; if (EX_redirect_pc !== e) begin fails++; $display("FAIL t2_redirect got=%0h exp=%0h", EX_redirect_pc, e); end
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t2_nobypass_hit got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      @(negedge clk); EX_update = 1'b0;
      sb.push_back(1); sb.push_back(32'h80); sb.push_back(4'b0001); sb.push_back(0); sb.push_back(0);
      #2;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t2_hit got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      e = sb.pop_front(); tests++; if (IF_target !== e) begin fails++; $display("FAIL t2_target got=%0h exp=%0h", IF_target, e); end
      e = sb.pop_front(); tests++; if (IF_pattern_used !== e[3:0]) begin fails++; $display("FAIL t2_pattern got=%0h exp=%0h", IF_pattern_used, e[3:0]); end
      e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL t2_idle_mp got=%0h exp=%0h", EX_mispredict, e[0]); end
      e = sb.pop_front(); tests++; if (EX_redirect_pc !== e) begin fails++; $display("FAIL t2_idle_redirect got=%0h exp=%0h", EX_redirect_pc, e); end
   endtask

   // PHT counter at idx 1 (pc 0x100, history 0001): up to ceiling, down to floor
   task automatic test_pht_saturation();
      logic [31:0] e;
      logic [8:0]  tk   = 9'b1_0000_1111;
      logic [8:0]  pred = 9'b0_0011_1110;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); IF_pc = 32'h100;
         drive_ex(1, 1, 32'h100, tk[i], 32'h80, 1, tk[i], 4'b0001);
         sb.push_back({31'd0, pred[i]}); sb.push_back(0);
         #2;
         e = sb.pop_front(); tests++; if (IF_prediction !== e[0]) begin fails++; $display("FAIL t3_pred[%0d] got=%0h exp=%0h", i, IF_prediction, e[0]); end
         e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL t3_mp[%0d] got=%0h exp=%0h", i, EX_mispredict, e[0]); end
      end
      @(negedge clk); EX_update = 1'b0; sb.push_back(0);
      #2;
      e = sb.pop_front(); tests++; if (IF_prediction !== e[0]) begin fails++; $display("FAIL t3_pred_final got=%0h exp=%0h", IF_prediction, e[0]); end
   endtask

   // Predicted taken, actually not taken: fall-through redirect, no allocation
   task automatic test_mispredict_nt();
      logic [31:0] e;
      @(negedge clk); IF_pc = 32'h200; drive_ex(1, 1, 32'h200, 0, 32'h0, 1, 1, 4'b0011);
      sb.push_back(1); sb.push_back(32'h204);
      #2;
      e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL t4_mp got=%0h exp=%0h", EX_mispredict, e[0]); end
      e = sb.pop_front(); tests++; if (EX_redirect_pc !== e) begin fails++; $display("FAIL t4_redirect got=%0h exp=%0h", EX_redirect_pc, e); end
      @(negedge clk); EX_update = 1'b0; sb.push_back(0); sb.push_back(4'b0010);
      #2;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t4_noalloc got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      e = sb.pop_front(); tests++; if (IF_pattern_used !== e[3:0]) begin fails++; $display("FAIL t4_recover got=%0h exp=%0h", IF_pattern_used, e[3:0]); end
      @(negedge clk); IF_pc = 32'h100; sb.push_back(1);
      #2;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t4_intact got=%0h exp=%0h", IF_BTB_hit, e[0]); end
   endtask

   // Jumps: train jal, predict taken without shifting history, retrain on jalr
   task automatic test_jump();
      logic [31:0] e;
      @(negedge clk); drive_ex(1, 0, 32'h300, 1, 32'h400, 0, 0, 4'b0010);
      sb.push_back(1); sb.push_back(32'h400);
      #2;
      e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL t5_jal_mp got=%0h exp=%0h", EX_mispredict, e[0]); end
      e = sb.pop_front(); tests++; if (EX_redirect_pc !== e) begin fails++; $display("FAIL t5_jal_redirect got=%0h exp=%0h", EX_redirect_pc, e); end
      @(negedge clk); EX_update = 1'b0; IF_pc = 32'h300; IF_stall = 1'b0;
      sb.push_back(1); sb.push_back(1); sb.push_back(32'h400);
      #2;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t5_hit got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      e = sb.pop_front(); tests++; if (IF_prediction !== e[0]) begin fails++; $display("FAIL t5_pred got=%0h exp=%0h", IF_prediction, e[0]); end
      e = sb.pop_front(); tests++; if (IF_target !== e) begin fails++; $display("FAIL t5_target got=%0h exp=%0h", IF_target, e); end
      @(negedge clk); sb.push_back(4'b0010);
      #2;
      e = sb.pop_front(); tests++; if (IF_pattern_used !== e[3:0]) begin fails++; $display("FAIL t5_noshift got=%0h exp=%0h", IF_pattern_used, e[3:0]); end
      @(negedge clk); IF_stall = 1'b1; drive_ex(1, 0, 32'h300, 1, 32'h500, 1, 1, 4'b0010);
      sb.push_back(1); sb.push_back(32'h500);
      #2;
      e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL t5_jalr_mp got=%0h exp=%0h", EX_mispredict, e[0]); end
      e = sb.pop_front(); tests++; if (EX_redirect_pc !== e) begin fails++; $display("FAIL t5_jalr_redirect got=%0h exp=%0h", EX_redirect_pc, e); end
      @(negedge clk); EX_update = 1'b0; sb.push_back(32'h500);
      #2;
      e = sb.pop_front(); tests++; if (IF_target !== e) begin fails++; $display("FAIL t5_retarget got=%0h exp=%0h", IF_target, e); end
      @(negedge clk); drive_ex(1, 0, 32'h300, 1, 32'h500, 1, 1, 4'b0010); sb.push_back(0);
      #2;
      e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL t5_jalr_correct got=%0h exp=%0h", EX_mispredict, e[0]); end
   endtask

   // Recovery vs speculative shift in the same cycle, then a plain shift
   task automatic test_back_to_back();
      logic [31:0] e;
      @(negedge clk); drive_ex(1, 1, 32'h104, 1, 32'h40, 0, 0, 4'h0);
      @(negedge clk); IF_pc = 32'h104; IF_stall = 1'b0; drive_ex(1, 1, 32'h200, 1, 32'h60, 0, 0, 4'h0);
      sb.push_back(1); sb.push_back(4'b0101); sb.push_back(1);
      #2;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t6_hit got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      e = sb.pop_front(); tests++; if (IF_pattern_used !== e[3:0]) begin fails++; $display("FAIL t6_pattern got=%0h exp=%0h", IF_pattern_used, e[3:0]); end
      e = sb.pop_front(); tests++; if (EX_mispredict !== e[0]) begin fails++; $display("FAIL t6_mp got=%0h exp=%0h", EX_mispredict, e[0]); end
      @(negedge clk); EX_update = 1'b0; IF_stall = 1'b1; sb.push_back(4'b1011);
      #2;
      e = sb.pop_front(); tests++; if (IF_pattern_used !== e[3:0]) begin fails++; $display("FAIL t6_priority got=%0h exp=%0h", IF_pattern_used, e[3:0]); end
      @(negedge clk); IF_stall = 1'b0; sb.push_back(0);
      #2;
      e = sb.pop_front(); tests++; if (IF_prediction !== e[0]) begin fails++; $display("FAIL t6_spec_pred got=%0h exp=%0h", IF_prediction, e[0]); end
      @(negedge clk); IF_stall = 1'b1; sb.push_back(4'b0110);
      #2;
      e = sb.pop_front(); tests++; if (IF_pattern_used !== e[3:0]) begin fails++; $display("FAIL t6_spec_shift got=%0h exp=%0h", IF_pattern_used, e[3:0]); end
   endtask

   // Async reset with an update in flight: everything cleared, update dropped
   task automatic test_reset_mid();
      logic [31:0] e;
      @(negedge clk); IF_pc = 32'h104; drive_ex(1, 1, 32'h108, 1, 32'h700, 0, 0, 4'h0);
      #1 reset = 1'b1;
      sb.push_back(0); sb.push_back(0);
      #1;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t7_async_hit got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      e = sb.pop_front(); tests++; if (IF_pattern_used !== e[3:0]) begin fails++; $display("FAIL t7_async_pattern got=%0h exp=%0h", IF_pattern_used, e[3:0]); end
      @(negedge clk); reset = 1'b0; EX_update = 1'b0; IF_pc = 32'h108; sb.push_back(0);
      #2;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t7_dropped got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      @(negedge clk); IF_pc = 32'h300; sb.push_back(0); sb.push_back(0);
      #2;
      e = sb.pop_front(); tests++; if (IF_BTB_hit !== e[0]) begin fails++; $display("FAIL t7_cleared got=%0h exp=%0h", IF_BTB_hit, e[0]); end
      e = sb.pop_front(); tests++; if (IF_prediction !== e[0]) begin fails++; $display("FAIL t7_pred got=%0h exp=%0h", IF_prediction, e[0]); end
   endtask

   initial begin
      reset = 1'b1; IF_pc = '0; IF_stall = 1'b1;
      drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 0, 4'h0);
      test_reset();
      test_first_train();
      test_pht_saturation();
      test_mispredict_nt();
      test_jump();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
